// File: rtl/rails_sequencer.sv
// rtl/rails_sequencer.sv - ordered, timed enable of the SMU LP15V/LP30V/LP60V rails and rail OE.
// Optional heartbeat watchdog is compiled in with RAILS_SEQ_WATCHDOG_EN.
module rails_sequencer #(
  parameter int CNT_W = 24,
  parameter int DWELL = 1000000,
  parameter int WDOG  = 16000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_on,
  input  logic       fault,
  input  logic       fault_clr,
  input  logic       kick,
  output logic       rails_lp15v,
  output logic       rails_lp30v,
  output logic       rails_lp60v,
  output logic       rails_oe_n,
  output logic [3:0] state,
  output logic [1:0] fault_cause,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_OFF   = 4'd0,
    S_UP15  = 4'd1,
    S_UP30  = 4'd2,
    S_UP60  = 4'd3,
    S_ON    = 4'd4,
    S_DNOE  = 4'd5,
    S_DN60  = 4'd6,
    S_DN30  = 4'd7,
    S_FAULT = 4'd8
  } state_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_fault_s1;
  logic             r_fault_s2;
  logic [CNT_W-1:0] r_dwell;
  logic             w_dwell_done;
  logic             w_wdog_exp;
  logic [2:0]       r_rails;
  logic             r_oe_n;
  logic             r_busy;
  logic [1:0]       r_cause;
  logic [2:0]       w_rails_next;
  logic             w_oe_n_next;
  logic             w_busy_next;
  logic [1:0]       w_cause_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault_s1 <= 1'b0;
      r_fault_s2 <= 1'b0;
    end else begin
      r_fault_s1 <= fault;
      r_fault_s2 <= r_fault_s1;
    end
  end

`ifdef RAILS_SEQ_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG - 1);

  logic [CNT_W-1:0] r_wdog;
  logic             w_wdog_idle;

  assign w_wdog_idle = (r_state == S_OFF) || (r_state == S_FAULT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
    end else if (kick || w_wdog_idle) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + CNT_W'(1);
    end
  end

  // A kick in the expiry cycle rescues the rails.
  assign w_wdog_exp = !kick && !w_wdog_idle && (r_wdog == WDOG_LAST);
`else
  logic             w_unused_kick;
  logic [CNT_W-1:0] w_unused_wdog;

  assign w_unused_kick = kick;
  assign w_unused_wdog = CNT_W'(WDOG);
  assign w_wdog_exp    = 1'b0;
`endif

  assign w_dwell_done = (r_dwell == DWELL_LAST);

  always_comb begin
    w_state_next = r_state;
    if (r_fault_s2 || w_wdog_exp) begin
      w_state_next = S_FAULT;
    end else begin
      unique case (r_state)
        S_OFF:   if (req_on) w_state_next = S_UP15;
        S_UP15:  if (!req_on) w_state_next = S_DN30;
                 else if (w_dwell_done) w_state_next = S_UP30;
        S_UP30:  if (!req_on) w_state_next = S_DN60;
                 else if (w_dwell_done) w_state_next = S_UP60;
        // OE was never driven during power-up, so an abort skips DNOE.
        S_UP60:  if (!req_on) w_state_next = S_DN60;
                 else if (w_dwell_done) w_state_next = S_ON;
        S_ON:    if (!req_on) w_state_next = S_DNOE;
        S_DNOE:  if (w_dwell_done) w_state_next = S_DN60;
        S_DN60:  if (w_dwell_done) w_state_next = S_DN30;
        S_DN30:  if (w_dwell_done) w_state_next = S_OFF;
        S_FAULT: if (fault_clr && !req_on) w_state_next = S_OFF;
        default: w_state_next = S_FAULT;
      endcase
    end
  end

  always_comb begin
    w_rails_next = 3'b000;
    w_oe_n_next  = 1'b1;
    w_busy_next  = 1'b0;
    unique case (w_state_next)
      S_UP15:  begin w_rails_next = 3'b001; w_busy_next = 1'b1; end
      S_UP30:  begin w_rails_next = 3'b011; w_busy_next = 1'b1; end
      S_UP60:  begin w_rails_next = 3'b111; w_busy_next = 1'b1; end
      S_ON:    begin w_rails_next = 3'b111; w_oe_n_next = 1'b0; end
      S_DNOE:  begin w_rails_next = 3'b111; w_busy_next = 1'b1; end
      S_DN60:  begin w_rails_next = 3'b011; w_busy_next = 1'b1; end
      S_DN30:  begin w_rails_next = 3'b001; w_busy_next = 1'b1; end
      default: begin w_rails_next = 3'b000; end
    endcase
  end

  always_comb begin
    w_cause_next = r_cause | {w_wdog_exp, r_fault_s2};
    if ((r_state == S_FAULT) && (w_state_next == S_OFF)) begin
      w_cause_next = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_OFF;
      r_rails <= 3'b000;
      r_oe_n  <= 1'b1;
      r_busy  <= 1'b0;
      r_cause <= 2'b00;
    end else begin
      r_state <= w_state_next;
      r_rails <= w_rails_next;
      r_oe_n  <= w_oe_n_next;
      r_busy  <= w_busy_next;
      r_cause <= w_cause_next;
    end
  end

  // Restarts on every state entry so each transient state lasts exactly DWELL cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dwell <= '0;
    end else if (w_state_next != r_state) begin
      r_dwell <= '0;
    end else if (r_busy) begin
      r_dwell <= r_dwell + CNT_W'(1);
    end
  end

  assign rails_lp15v = r_rails[0];
  assign rails_lp30v = r_rails[1];
  assign rails_lp60v = r_rails[2];
  assign rails_oe_n  = r_oe_n;
  assign state       = r_state;
  assign fault_cause = r_cause;
  assign busy        = r_busy;

endmodule

// File: tb/tb_rails_sequencer.sv
// tb/tb_rails_sequencer.sv - directed scoreboard bench for rails_sequencer (DWELL=4, WDOG=32).
module tb_rails_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_on;
  logic       fault;
  logic       fault_clr;
  logic       kick;
  logic       rails_lp15v;
  logic       rails_lp30v;
  logic       rails_lp60v;
  logic       rails_oe_n;
  logic [3:0] state;
  logic [1:0] fault_cause;
  logic       busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [10:0] vec;
  } exp_t;

  exp_t sb[$];

  rails_sequencer #(.CNT_W(8), .DWELL(4), .WDOG(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_on      (req_on),
    .fault       (fault),
    .fault_clr   (fault_clr),
    .kick        (kick),
    .rails_lp15v (rails_lp15v),
    .rails_lp30v (rails_lp30v),
    .rails_lp60v (rails_lp60v),
    .rails_oe_n  (rails_oe_n),
    .state       (state),
    .fault_cause (fault_cause),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Expected {state, rails60/30/15, oe_n, cause, busy} from the state table.
  function automatic logic [10:0] ev(input logic [3:0] s, input logic [1:0] c);
    logic [2:0] r;
    logic       oe_n;
    logic       b;
    r    = 3'b000;
    oe_n = 1'b1;
    b    = 1'b0;
    case (s)
      4'd1: begin r = 3'b001; b = 1'b1; end
      4'd2: begin r = 3'b011; b = 1'b1; end
      4'd3: begin r = 3'b111; b = 1'b1; end
      4'd4: begin r = 3'b111; oe_n = 1'b0; end
      4'd5: begin r = 3'b111; b = 1'b1; end
      4'd6: begin r = 3'b011; b = 1'b1; end
      4'd7: begin r = 3'b001; b = 1'b1; end
      default: r = 3'b000;
    endcase
    return {s, r, oe_n, c, b};
  endfunction

  function automatic logic [10:0] obs();
    return {state, rails_lp60v, rails_lp30v, rails_lp15v, rails_oe_n, fault_cause, busy};
  endfunction

  task automatic push(input string tag, input logic [3:0] s, input logic [1:0] c, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.tag = tag;
      e.vec = ev(s, c);
      sb.push_back(e);
    end
  endtask

  task automatic check_now();
    exp_t        e;
    logic [10:0] o;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL sb_empty observed=%h required=queued_entry", obs());
    end else begin
      e = sb.pop_front();
      o = obs();
      assert (o === e.vec) else begin
        bad++;
        $error("FAIL %s observed=%h required=%h", e.tag, o, e.vec);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_now();
    end
  endtask

  task automatic push_up(input string tag);
    push({tag, "_up15"}, 4'd1, 2'b00, 4);
    push({tag, "_up30"}, 4'd2, 2'b00, 4);
    push({tag, "_up60"}, 4'd3, 2'b00, 4);
    push({tag, "_on"},   4'd4, 2'b00, 1);
  endtask

  task automatic push_down(input string tag);
    push({tag, "_dnoe"}, 4'd5, 2'b00, 4);
    push({tag, "_dn60"}, 4'd6, 2'b00, 4);
    push({tag, "_dn30"}, 4'd7, 2'b00, 4);
    push({tag, "_off"},  4'd0, 2'b00, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst_n     = 1'b0;
    req_on    = 1'b0;
    fault     = 1'b0;
    fault_clr = 1'b0;
    kick      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    push("reset", 4'd0, 2'b00, 1);
    check_now();
    rst_n = 1'b1;
    push("idle", 4'd0, 2'b00, 1);
    run(1);

    // Power-up then power-down.
    req_on = 1'b1;
    push_up("pu");
    push("pu_on_hold", 4'd4, 2'b00, 2);
    run(15);
    req_on = 1'b0;
    push_down("pd");
    push("pd_off_hold", 4'd0, 2'b00, 1);
    run(14);

    // Abort two cycles into UP30.
    req_on = 1'b1;
    push("ab_up15", 4'd1, 2'b00, 4);
    push("ab_up30", 4'd2, 2'b00, 2);
    run(6);
    req_on = 1'b0;
    push("ab_dn60", 4'd6, 2'b00, 4);
    push("ab_dn30", 4'd7, 2'b00, 4);
    push("ab_off",  4'd0, 2'b00, 1);
    run(9);

    // Fault while ON, clear blocked while req_on is high.
    req_on = 1'b1;
    push_up("fo");
    run(13);
    fault = 1'b1;
    push("fo_sync", 4'd4, 2'b00, 2);
    run(2);
    fault = 1'b0;
    push("fo_fault", 4'd8, 2'b01, 1);
    run(1);
    fault_clr = 1'b1;
    push("fo_hold", 4'd8, 2'b01, 4);
    run(4);
    req_on = 1'b0;
    push("fo_clear", 4'd0, 2'b00, 3);
    run(1);
    fault_clr = 1'b0;
    run(2);

    // Synchronised fault and req_on in the same cycle while OFF.
    fault = 1'b1;
    push("fr_sync", 4'd0, 2'b00, 2);
    run(2);
    req_on = 1'b1;
    push("fr_fault", 4'd8, 2'b01, 3);
    run(3);
    fault     = 1'b0;
    req_on    = 1'b0;
    fault_clr = 1'b1;
    push("fr_drain", 4'd8, 2'b01, 2);
    push("fr_off",   4'd0, 2'b00, 1);
    run(3);
    fault_clr = 1'b0;

`ifdef RAILS_SEQ_WATCHDOG_EN
    req_on = 1'b1;
    kick   = 1'b1;
    push_up("wd");
    run(13);
    kick = 1'b0;
    push("wd_on",  4'd4, 2'b00, 31);
    push("wd_exp", 4'd8, 2'b10, 1);
    run(32);
    kick      = 1'b1;
    req_on    = 1'b0;
    fault_clr = 1'b1;
    push("wd_clear", 4'd0, 2'b00, 1);
    run(1);
    fault_clr = 1'b0;

    req_on = 1'b1;
    push_up("wk");
    run(13);
    for (int k = 0; k < 3; k++) begin
      kick = 1'b0;
      push("wk_quiet", 4'd4, 2'b00, 31);
      run(31);
      kick = 1'b1;
      push("wk_edge", 4'd4, 2'b00, 1);
      run(1);
    end
    req_on = 1'b0;
    push_down("wk_pd");
    run(13);
`else
    req_on = 1'b1;
    kick   = 1'b0;
    push_up("nw");
    push("nw_on_hold", 4'd4, 2'b00, 40);
    run(53);
    req_on = 1'b0;
    push_down("nw_pd");
    run(13);
`endif

    // Asynchronous reset during UP60.
    kick   = 1'b1;
    req_on = 1'b1;
    push("rs_up15", 4'd1, 2'b00, 4);
    push("rs_up30", 4'd2, 2'b00, 4);
    push("rs_up60", 4'd3, 2'b00, 2);
    run(10);
    rst_n = 1'b0;
    #2;
    push("rs_async", 4'd0, 2'b00, 1);
    check_now();
    req_on = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push("rs_after", 4'd0, 2'b00, 2);
    run(2);

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL sb_leftover observed=%0d required=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rails_sequencer.md
# rails_sequencer

Power-rail sequencer for the SMU analog supplies. It turns a single level request from the register bank into an ordered, timed enable sequence of LP15V, LP30V and LP60V and the active-low rail output enable. It drops everything immediately on an external fault or, optionally, on a lost SPI heartbeat. It sits between the rails register bits and the RAILS_* pins in top, replacing their direct assignment.

## Interface
- `CNT_W`, default 24: width of the dwell and watchdog counters.
- `DWELL`, default 1000000: clk cycles spent in each sequencing step. Legal range is 1..2^CNT_W-1.
- `WDOG`, default 16000000: heartbeat timeout in clk cycles. Legal range is 2..2^CNT_W-1.
- `clk` in, 1 bit: sole clock, rising edge.
- `rst_n` in, 1 bit: reset, asynchronous assert, active-low.
- `req_on` in, 1 bit: level request, 1 = rails on. Synchronous to clk.
- `fault` in, 1 bit: external overcurrent/clamp fault, asynchronous. Internally double-flop synchronised.
- `fault_clr` in, 1 bit: clears a latched fault. Synchronous to clk.
- `kick` in, 1 bit: heartbeat strobe, one clk pulse per SPI write. Ignored unless the watchdog is compiled in.
- `rails_lp15v`, `rails_lp30v`, `rails_lp60v` out, 1 bit each: rail enables, active-high.
- `rails_oe_n` out, 1 bit: rail output enable, active-low.
- `state` out, 4 bits: current state encoding, for register readback.
- `fault_cause` out, 2 bits: sticky fault cause. Bit 0 = fault pin, bit 1 = watchdog.
- `busy` out, 1 bit: 1 in any transient state.

## Operation
- All outputs are registered and change on the same edge as `state`.
- State encodings and outputs, given as {60,30,15} then oe_n:

| Encoding | State | Rails {60,30,15} | oe_n |
|---|---|---|---|
| 0 | OFF | 000 | 1 |
| 1 | UP15 | 001 | 1 |
| 2 | UP30 | 011 | 1 |
| 3 | UP60 | 111 | 1 |
| 4 | ON | 111 | 0 |
| 5 | DNOE | 111 | 1 |
| 6 | DN60 | 011 | 1 |
| 7 | DN30 | 001 | 1 |
| 8 | FAULT | 000 | 1 |

- Transitions, with "dwell" meaning the dwell counter has reached DWELL-1:
  - OFF goes to UP15 when `req_on`=1.
  - UP15 goes to UP30 on dwell. UP30 goes to UP60 on dwell. UP60 goes to ON on dwell.
  - ON goes to DNOE when `req_on`=0.
  - DNOE goes to DN60 on dwell. DN60 goes to DN30 on dwell. DN30 goes to OFF on dwell.
- Abort during power-up when `req_on`=0 is sampled:
  - UP15 goes to DN30.
  - UP30 goes to DN60.
  - UP60 goes to DN60. OE was never asserted, so DNOE is skipped.
- Power-down is never aborted by `req_on` returning to 1. It completes to OFF, then restarts from OFF on the next edge if `req_on`=1.
- The dwell counter clears on every state entry and counts up while in a transient state. Each transient state therefore lasts exactly DWELL cycles.
- `busy`=1 in states 1-3 and 5-7.
- Fault handling:
  - The synchronised fault at 1 in any state, including OFF, forces FAULT on the next edge and sets `fault_cause`[0].
  - FAULT goes to OFF only when `fault_clr`=1, synchronised fault=0 and `req_on`=0 are all true in the same cycle.
  - `fault_cause` clears on that same edge.
- Priority:
  - Fault beats `req_on` and dwell expiry in the same cycle.
  - Fault pin and watchdog expiring in the same cycle set both cause bits.
  - `fault_clr` has no effect outside FAULT.

## Timing
- Reset values:
  - `state`=OFF.
  - All rail outputs 0.
  - `rails_oe_n`=1.
  - `fault_cause`=0, `busy`=0.
  - Counters and synchroniser flops 0.
- `req_on` rising in OFF at edge N: `rails_lp15v`=1 after edge N+1. LP30V follows DWELL cycles later, LP60V DWELL after that, and `rails_oe_n`=0 at 3×DWELL+1 edges after N.
- Power-down from ON: `rails_oe_n`=1 one edge after `req_on`=0 is sampled. LP60V, LP30V and LP15V each drop DWELL cycles after the previous step.
- Fault latency: `fault` first sampled high at edge N gives all outputs off and `state`=FAULT after edge N+2. The pulse must be held at least 2 clk cycles to be guaranteed capture.
- Reset asserted mid-sequence forces all outputs to reset values immediately, asynchronously, with no ordered shutdown.

## Configuration
- `RAILS_SEQ_WATCHDOG_EN` defined:
  - A watchdog counter clears on `kick`, and is held at 0 in OFF and FAULT.
  - In any other state, reaching WDOG-1 forces FAULT on the next edge and sets `fault_cause`[1].
  - `kick` in the expiry cycle wins, so no fault is raised.
- `RAILS_SEQ_WATCHDOG_EN` undefined:
  - No watchdog logic is synthesised and `kick` is unused.
  - `fault_cause`[1] is constant 0.

## Test plan
All scenarios run with the bench using DWELL=4 and WDOG=32.
- **Power-up and power-down.** Raise `req_on` in OFF at cycle 0.
  - Expect LP15V at cycle 1, LP30V at 5, LP60V at 9 and `rails_oe_n`=0 at 13.
  - Drop `req_on` and expect `rails_oe_n`=1 after 1 cycle, then LP60V, LP30V and LP15V each off 4 cycles apart; `state` ends at 0 and `busy`=0.
- **Abort during UP30.** Drop `req_on` 2 cycles into UP30.
  - Expect `state`=6 next cycle with LP60V never asserted, then DN30, then OFF after 8 further cycles.
- **Fault while ON.** Assert `fault` for 2 cycles.
  - Expect all rails 0, `rails_oe_n`=1, `state`=8 and `fault_cause`=01 within 3 edges.
  - With `fault_clr`=1 and `req_on`=1, expect FAULT to hold. Drop `req_on` and expect OFF with `fault_cause`=00.
- **Fault beats request.** Assert `fault` in OFF together with `req_on`.
  - Expect no rail to ever assert and `state`=8.
- **Watchdog, macro defined.** Reach ON, then give no `kick` for 32 cycles.
  - Expect FAULT with `fault_cause`=10.
  - Repeat with `kick` every 31 cycles and expect ON to hold. `kick` arriving on the expiry cycle must prevent the fault.
- **Reset mid-sequence.** Pulse `rst_n` low during UP60.
  - Expect all outputs at their reset values asynchronously, with no ordered shutdown.
